// File: rtl/shift_unit_pipe.sv
// Pipelined barrel shifter for the EX stage: SLL/SRL/SRA with valid/ready handshake, tag sideband and flush.
// Optional macro SHIFT_UNIT_ROR_EN turns op 2'b11 into rotate-right; without it op 2'b11 behaves as SRL.
module shift_unit_pipe #(
  parameter int XLEN        = 32,
  parameter int PIPE_STAGES = 2,
  parameter int TAG_W       = 5
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [1:0]              i_op,
  input  logic [XLEN-1:0]         i_data,
  input  logic [$clog2(XLEN)-1:0] i_shamt,
  input  logic [TAG_W-1:0]        i_tag,
  input  logic                    i_flush,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [XLEN-1:0]         o_data,
  output logic [TAG_W-1:0]        o_tag
);

  localparam int SW   = $clog2(XLEN);
  localparam int LPS  = (SW + PIPE_STAGES - 1) / PIPE_STAGES;
  localparam int LAST = PIPE_STAGES - 1;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
`ifdef SHIFT_UNIT_ROR_EN
  localparam logic [1:0] OP_ROR = 2'b11;
`endif

  function automatic logic [XLEN-1:0] bit_rev(input logic [XLEN-1:0] d);
    logic [XLEN-1:0] r;
    for (int i = 0; i < XLEN; i++) begin
      r[i] = d[XLEN-1-i];
    end
    return r;
  endfunction

  function automatic logic [XLEN-1:0] fill_level(input logic [XLEN-1:0] d, input int k, input logic fill);
    logic [XLEN-1:0] mask;
    mask = ~({XLEN{1'b1}} >> (1 << k));
    return (d >> (1 << k)) | (mask & {XLEN{fill}});
  endfunction

`ifdef SHIFT_UNIT_ROR_EN
  function automatic logic [XLEN-1:0] rotate_level(input logic [XLEN-1:0] d, input int k);
    return (d >> (1 << k)) | (d << (XLEN - (1 << k)));
  endfunction
`endif

  logic [XLEN-1:0]        data0_s;
  logic                   rev0_s;
  logic                   fill0_s;

  logic [XLEN-1:0]        stg_in_data_s  [PIPE_STAGES];
  logic [SW-1:0]          stg_in_shamt_s [PIPE_STAGES];
  logic                   stg_in_fill_s  [PIPE_STAGES];
  logic                   stg_in_rev_s   [PIPE_STAGES];
  logic [TAG_W-1:0]       stg_in_tag_s   [PIPE_STAGES];
  logic                   stg_in_valid_s [PIPE_STAGES];
  logic [XLEN-1:0]        stg_out_data_s [PIPE_STAGES];

  logic [PIPE_STAGES-1:0] valid_r;
  logic [XLEN-1:0]        data_r  [PIPE_STAGES];
  logic [SW-1:0]          shamt_r [PIPE_STAGES];
  logic                   fill_r  [PIPE_STAGES];
  logic                   rev_r   [PIPE_STAGES];
  logic [TAG_W-1:0]       tag_r   [PIPE_STAGES];
  logic [PIPE_STAGES-1:0] adv_s;

`ifdef SHIFT_UNIT_ROR_EN
  logic                   rot0_s;
  logic                   stg_in_rot_s [PIPE_STAGES];
  logic                   rot_r        [PIPE_STAGES];
`endif

  // Op decode: SLL runs through the right shifter on a bit-reversed operand.
  always_comb begin
    rev0_s  = 1'b0;
    fill0_s = 1'b0;
`ifdef SHIFT_UNIT_ROR_EN
    rot0_s  = 1'b0;
`endif
    case (i_op)
      OP_SLL:  rev0_s  = 1'b1;
      OP_SRL:  rev0_s  = 1'b0;
      OP_SRA:  fill0_s = i_data[XLEN-1];
`ifdef SHIFT_UNIT_ROR_EN
      OP_ROR:  rot0_s  = 1'b1;
`endif
      default: rev0_s  = 1'b0;
    endcase
    if (rev0_s) begin
      data0_s = bit_rev(i_data);
    end else begin
      data0_s = i_data;
    end
  end

  for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_stage
    logic [XLEN-1:0] shifted_s;
    logic [XLEN-1:0] out_s;

    if (s == 0) begin : g_head
      assign stg_in_data_s[s]  = data0_s;
      assign stg_in_shamt_s[s] = i_shamt;
      assign stg_in_fill_s[s]  = fill0_s;
      assign stg_in_rev_s[s]   = rev0_s;
      assign stg_in_tag_s[s]   = i_tag;
      assign stg_in_valid_s[s] = i_valid;
`ifdef SHIFT_UNIT_ROR_EN
      assign stg_in_rot_s[s]   = rot0_s;
`endif
    end else begin : g_body
      assign stg_in_data_s[s]  = data_r[s-1];
      assign stg_in_shamt_s[s] = shamt_r[s-1];
      assign stg_in_fill_s[s]  = fill_r[s-1];
      assign stg_in_rev_s[s]   = rev_r[s-1];
      assign stg_in_tag_s[s]   = tag_r[s-1];
      assign stg_in_valid_s[s] = valid_r[s-1];
`ifdef SHIFT_UNIT_ROR_EN
      assign stg_in_rot_s[s]   = rot_r[s-1];
`endif
    end

    // Shift levels owned by this stage; the last stage also undoes the SLL reversal.
    always_comb begin
      shifted_s = stg_in_data_s[s];
      for (int k = 0; k < SW; k++) begin
        if (((k / LPS) == s) && stg_in_shamt_s[s][k]) begin
`ifdef SHIFT_UNIT_ROR_EN
          if (stg_in_rot_s[s]) begin
            shifted_s = rotate_level(shifted_s, k);
          end else begin
            shifted_s = fill_level(shifted_s, k, stg_in_fill_s[s]);
          end
`else
          shifted_s = fill_level(shifted_s, k, stg_in_fill_s[s]);
`endif
        end else begin
          shifted_s = shifted_s;
        end
      end
      if ((s == LAST) && stg_in_rev_s[s]) begin
        out_s = bit_rev(shifted_s);
      end else begin
        out_s = shifted_s;
      end
    end

    assign stg_out_data_s[s] = out_s;
  end

  // Backpressure chain: a stage moves when it is empty or its successor moves.
  always_comb begin
    adv_s       = {PIPE_STAGES{1'b0}};
    adv_s[LAST] = !valid_r[LAST] || i_ready;
    for (int s = LAST - 1; s >= 0; s--) begin
      adv_s[s] = !valid_r[s] || adv_s[s+1];
    end
  end

  // Stage registers; flush beats advance, payload only loads for a valid operation.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      valid_r <= {PIPE_STAGES{1'b0}};
      for (int s = 0; s < PIPE_STAGES; s++) begin
        data_r[s]  <= {XLEN{1'b0}};
        shamt_r[s] <= {SW{1'b0}};
        fill_r[s]  <= 1'b0;
        rev_r[s]   <= 1'b0;
        tag_r[s]   <= {TAG_W{1'b0}};
`ifdef SHIFT_UNIT_ROR_EN
        rot_r[s]   <= 1'b0;
`endif
      end
    end else begin
      for (int s = 0; s < PIPE_STAGES; s++) begin
        if (i_flush) begin
          valid_r[s] <= 1'b0;
        end else if (adv_s[s]) begin
          valid_r[s] <= stg_in_valid_s[s];
        end else begin
          valid_r[s] <= valid_r[s];
        end
        if (adv_s[s] && stg_in_valid_s[s]) begin
          data_r[s]  <= stg_out_data_s[s];
          shamt_r[s] <= stg_in_shamt_s[s];
          fill_r[s]  <= stg_in_fill_s[s];
          rev_r[s]   <= stg_in_rev_s[s];
          tag_r[s]   <= stg_in_tag_s[s];
`ifdef SHIFT_UNIT_ROR_EN
          rot_r[s]   <= stg_in_rot_s[s];
`endif
        end
      end
    end
  end

  assign o_ready = adv_s[0];
  assign o_valid = valid_r[LAST];
  assign o_data  = data_r[LAST];
  assign o_tag   = tag_r[LAST];

endmodule

// File: doc/shift_unit_pipe.md
Name: shift_unit_pipe

Overview:
Parametrised, pipelined barrel shifter for the pipeline EX stage. It supports SLL, SRL and SRA, with ROR available as a compile-time option. It replaces the single-function combinational right shifter. Operations enter and leave through valid/ready handshakes, carry a destination tag, and can be flushed on branch mispredict.

Parameters:
XLEN, 32, data width; power of two, at least 8.
PIPE_STAGES, 2, register stages = latency in cycles; range 1..$clog2(XLEN).
TAG_W, 5, width of sideband tag (rd index) carried alongside the data.

Ports:
i_clk  in  1  clock, rising edge.
i_reset  in  1  asynchronous reset, active-high.
i_valid  in  1  input operation valid.
o_ready  out  1  unit can accept an operation this cycle.
i_op  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROR (see optional feature).
i_data  in  XLEN  operand (rs1).
i_shamt  in  $clog2(XLEN)  shift amount, low bits of rs2/imm.
i_tag  in  TAG_W  sideband tag.
i_flush  in  1  synchronous kill of all in-flight operations.
o_valid  out  1  result valid.
i_ready  in  1  downstream accepts the result.
o_data  out  XLEN  result.
o_tag  out  TAG_W  tag of the result.

Behaviour:
- Clock and reset: one clock, i_clk. i_reset is asynchronous and active-high.
- Reset values: all stage valid bits = 0, all data/tag registers = 0, so o_valid = 0, o_data = 0, o_tag = 0. Reset takes effect immediately, mid-operation included; in-flight operations are lost.
- Datapath:
  - $clog2(XLEN) shift levels, level k shifts by 2^k when i_shamt[k] is 1.
  - SLL is computed as bit-reverse, logical right shift, bit-reverse.
  - SRA fills with i_data[XLEN-1]; SRL fills with zero.
  - ROR fills with the bits shifted out.
- Pipelining:
  - Registers are inserted after every ceil($clog2(XLEN)/PIPE_STAGES) levels. The last register drives o_data/o_tag directly.
  - Op, tag and fill/reverse controls travel with the partial result.
- Latency: an operation accepted at edge N appears with o_valid = 1 after edge N+PIPE_STAGES-1, i.e. PIPE_STAGES cycles after i_valid && o_ready.
- Handshake:
  - A transfer occurs on an edge where valid && ready.
  - Stage s advances when it is empty or stage s+1 advances; the last stage advances when !o_valid || i_ready.
  - o_ready equals the advance condition of stage 0. It may depend combinationally on i_ready.
  - Full throughput: 1 op/cycle while i_ready = 1.
- Stall: while o_valid && !i_ready, o_data/o_tag/o_valid hold stable. Upstream stages fill their bubbles, then hold. With all stages full, o_ready = 0.
- Flush:
  - i_flush = 1 clears every valid bit at the next edge. The input presented that cycle is dropped, even if i_valid && o_ready.
  - Flush has priority over accept and advance.
  - Data registers need not clear.
- Simultaneous events: a stage that advances out and accepts new data in the same edge keeps valid = 1 with the new data; no bubble is inserted.
- Boundaries: i_shamt = 0 returns i_data unchanged for every op. The maximum shamt XLEN-1 is exact. i_shamt has no extra bits, so there is no modulo logic.
- Ordering: results leave in strict acceptance order. Nothing is dropped except by flush or reset.

Optional Feature:
Macro SHIFT_UNIT_ROR_EN.
- Defined: op 11 = rotate right by i_shamt (Zbb ror/rori).
- Undefined: op 11 decodes as SRL (identical to 01), and the rotate wrap path is not synthesised.

Test Plan:
1. XLEN=32, PIPE_STAGES=2. SRL 0x8000_0000 by 31, tag 7 -> o_data 0x0000_0001, o_tag 7, o_valid exactly 2 cycles after accept.
2. SRA 0x8000_0000 by 4 -> 0xF800_0000. SLL 0x0000_0001 by 31 -> 0x8000_0000. SRA 0x7FFF_FFFF by 31 -> 0x0000_0000. Any op with shamt 0 on 0xDEAD_BEEF -> 0xDEAD_BEEF.
3. Eight back-to-back ops, i_ready = 0 for cycles 3-5 -> all 8 results in order, no duplicates. o_data stable during the stall. o_ready = 0 once both stages are full; throughput returns to 1/cycle afterwards.
4. Two ops in flight, i_flush pulsed with a third op valid -> o_valid = 0 next cycle; none of the three appear; the next accepted op has normal latency.
5. i_reset asserted asynchronously between edges with ops in flight -> o_valid, o_data and o_tag go to 0 immediately. After release, the first op completes correctly.
6. op 11 on 0x0000_00F1 by 4 -> 0x1000_000F with SHIFT_UNIT_ROR_EN defined; 0x0000_000F without it.
